// File: rtl/uart_rx_param.sv
// Oversampled UART receiver with configurable frame format, valid/ready output and error flags.
// Line-break detection is built only when UART_RX_BREAK_DET_EN is defined.
module uart_rx_param #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD       = 115200,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] dout,
    output logic                 dout_valid,
    input  logic                 dout_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy,
    output logic                 break_det
);
    localparam int DIV = CLK_FREQ / (BAUD * OVERSAMPLE);
    localparam int TW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int SW  = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0] TICK_LAST = TW'(DIV - 1);
    localparam logic [SW-1:0] SMP_LAST  = SW'(OVERSAMPLE - 1);
    localparam logic [SW-1:0] SMP_A     = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] SMP_B     = SW'(OVERSAMPLE / 2);
    localparam logic [SW-1:0] SMP_C     = SW'(OVERSAMPLE / 2 + 1);
    localparam logic [2:0]    BIT_LAST  = 3'(DATA_BITS - 1);
    localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP, BRK} state_t;

    state_t                 state_q;
    logic                   rx_s1_q, rx_s2_q, rx_prev_q;
    logic [1:0]             arm_cnt_q;
    logic [TW-1:0]          tick_cnt_q;
    logic [SW-1:0]          smp_cnt_q;
    logic [2:0]             bit_cnt_q;
    logic                   stop_cnt_q;
    logic                   s0_q, s1_q;
    logic [DATA_BITS-1:0]   shift_q;
    logic                   perr_q, ferr_q, done_q, busy_q;
    logic [DATA_BITS-1:0]   dout_q;
    logic                   dout_valid_q, parity_err_q, frame_err_q, overrun_q;

    logic tick, decide, maj, par_x, armed, start_edge;

    assign tick       = (tick_cnt_q == TICK_LAST);
    assign decide     = tick && (smp_cnt_q == SMP_C);
    assign maj        = (s0_q & s1_q) | (s0_q & rx_s2_q) | (s1_q & rx_s2_q);
    assign par_x      = (^shift_q) ^ maj;
    // Arming needs three synced highs so the synchroniser's reset value cannot fake an idle line.
    assign armed      = (arm_cnt_q == 2'd3);
    assign start_edge = (state_q == IDLE) && armed && rx_prev_q && !rx_s2_q;

`ifdef UART_RX_BREAK_DET_EN
    logic          zero_q, break_q;
    logic [SW-1:0] hold_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zero_q <= 1'b0;
        end else if (decide) begin
            zero_q <= (state_q == START) ? ~maj : (zero_q & ~maj);
        end
    end
    assign break_det = break_q;
`else
    assign break_det = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            rx_s1_q    <= 1'b1;
            rx_s2_q    <= 1'b1;
            rx_prev_q  <= 1'b1;
            arm_cnt_q  <= 2'd0;
            tick_cnt_q <= '0;
            smp_cnt_q  <= '0;
            bit_cnt_q  <= 3'd0;
            stop_cnt_q <= 1'b0;
            s0_q       <= 1'b1;
            s1_q       <= 1'b1;
            shift_q    <= '0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
            break_q    <= 1'b0;
            hold_cnt_q <= '0;
`endif
        end else begin
            rx_s1_q   <= rx;
            rx_s2_q   <= rx_s1_q;
            rx_prev_q <= rx_s2_q;
            done_q    <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
            break_q   <= 1'b0;
`endif
            if (!armed) arm_cnt_q <= rx_s2_q ? (arm_cnt_q + 2'd1) : 2'd0;

            if (start_edge) begin
                tick_cnt_q <= '0;
                smp_cnt_q  <= '0;
            end else if (tick) begin
                tick_cnt_q <= '0;
                smp_cnt_q  <= (smp_cnt_q == SMP_LAST) ? '0 : (smp_cnt_q + SW'(1));
            end else begin
                tick_cnt_q <= tick_cnt_q + TW'(1);
            end

            if (tick && smp_cnt_q == SMP_A) s0_q <= rx_s2_q;
            if (tick && smp_cnt_q == SMP_B) s1_q <= rx_s2_q;

            case (state_q)
                IDLE: begin
                    if (start_edge) begin
                        state_q <= START;
                        busy_q  <= 1'b1;
                    end
                end
                START: begin
                    if (decide) begin
                        if (!maj) begin
                            state_q    <= DATA;
                            bit_cnt_q  <= 3'd0;
                            stop_cnt_q <= 1'b0;
                            perr_q     <= 1'b0;
                            ferr_q     <= 1'b0;
                        end else begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end
                    end
                end
                DATA: begin
                    if (decide) begin
                        shift_q   <= {maj, shift_q[DATA_BITS-1:1]};
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                        if (bit_cnt_q == BIT_LAST) state_q <= (PARITY != 0) ? PAR : STOP;
                    end
                end
                PAR: begin
                    if (decide) begin
                        perr_q  <= (PARITY == 1) ? ~par_x : par_x;
                        state_q <= STOP;
                    end
                end
                STOP: begin
                    if (decide) begin
                        ferr_q     <= ferr_q | ~maj;
                        stop_cnt_q <= stop_cnt_q + 1'b1;
                        // Leave at the mid-bit sample so the next start edge can be caught early.
                        if (stop_cnt_q == STOP_LAST) begin
                            busy_q  <= 1'b0;
                            state_q <= IDLE;
`ifdef UART_RX_BREAK_DET_EN
                            if (zero_q && !maj) begin
                                state_q    <= BRK;
                                break_q    <= 1'b1;
                                hold_cnt_q <= '0;
                            end else begin
                                done_q <= 1'b1;
                            end
`else
                            done_q <= 1'b1;
`endif
                        end
                    end
                end
`ifdef UART_RX_BREAK_DET_EN
                BRK: begin
                    if (!rx_s2_q) begin
                        hold_cnt_q <= '0;
                    end else if (tick) begin
                        if (hold_cnt_q == SMP_LAST) state_q <= IDLE;
                        else hold_cnt_q <= hold_cnt_q + SW'(1);
                    end
                end
`endif
                default: state_q <= IDLE;
            endcase
        end
    end

    // Output holding register: a completed frame loads only if the slot is free or being accepted now.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            overrun_q <= 1'b0;
            if (done_q) begin
                if (!dout_valid_q || dout_ready) begin
                    dout_q       <= shift_q;
                    parity_err_q <= perr_q;
                    frame_err_q  <= ferr_q;
                    dout_valid_q <= 1'b1;
                end else begin
                    overrun_q <= 1'b1;
                end
            end else if (dout_valid_q && dout_ready) begin
                dout_valid_q <= 1'b0;
            end
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign overrun    = overrun_q;
    assign busy       = busy_q;
endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: three receivers with different frame formats, table-driven frames
// checked through a per-receiver scoreboard, plus hand-written overrun, glitch/reset and break sequences.
module tb_uart_rx_param;
    localparam int CLK_FREQ = 1_600_000;
    localparam int BAUD     = 25_000;
    localparam int OS       = 16;
    localparam int BIT      = (CLK_FREQ / (BAUD * OS)) * OS;

    typedef struct packed {
        logic [7:0] d;
        logic       pe;
        logic       fe;
    } exp_t;

    typedef struct {
        int         sel;
        logic [7:0] d;
        int         nb;
        int         pm;
        bit         flip;
        int         ns;
        bit         s2low;
        int         gap;
        logic [7:0] ed;
        logic       epe;
        logic       efe;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    logic rx_l [3];
    logic ready_l [3];

    logic [7:0] dout0, dout2;
    logic [6:0] dout1;
    logic [2:0] vld, pe, fe, ovr, bsy, brk;
    logic [7:0] dout_w [3];

    exp_t q0[$], q1[$], q2[$];
    int   n_cmp = 0;
    int   n_fail = 0;
    int   ovr_cnt [3] = '{0, 0, 0};
    int   brk_cnt [3] = '{0, 0, 0};
    vec_t tbl [6];

    always #5 clk = ~clk;

    uart_rx_param #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .OVERSAMPLE(OS),
                    .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u0 (
        .clk(clk), .rst_n(rst_n), .rx(rx_l[0]), .dout(dout0), .dout_valid(vld[0]),
        .dout_ready(ready_l[0]), .parity_err(pe[0]), .frame_err(fe[0]), .overrun(ovr[0]),
        .busy(bsy[0]), .break_det(brk[0]));

    uart_rx_param #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .OVERSAMPLE(OS),
                    .DATA_BITS(7), .PARITY(2), .STOP_BITS(1)) u1 (
        .clk(clk), .rst_n(rst_n), .rx(rx_l[1]), .dout(dout1), .dout_valid(vld[1]),
        .dout_ready(ready_l[1]), .parity_err(pe[1]), .frame_err(fe[1]), .overrun(ovr[1]),
        .busy(bsy[1]), .break_det(brk[1]));

    uart_rx_param #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .OVERSAMPLE(OS),
                    .DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) u2 (
        .clk(clk), .rst_n(rst_n), .rx(rx_l[2]), .dout(dout2), .dout_valid(vld[2]),
        .dout_ready(ready_l[2]), .parity_err(pe[2]), .frame_err(fe[2]), .overrun(ovr[2]),
        .busy(bsy[2]), .break_det(brk[2]));

    assign dout_w[0] = dout0;
    assign dout_w[1] = {1'b0, dout1};
    assign dout_w[2] = dout2;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endfunction

    function automatic void push(int sel, exp_t e);
        case (sel)
            0: q0.push_back(e);
            1: q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endfunction

    function automatic void sb_pop(int sel);
        exp_t e;
        bit   have;
        have = 1'b0;
        e    = '0;
        case (sel)
            0: if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
            1: if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
            default: if (q2.size() > 0) begin e = q2.pop_front(); have = 1'b1; end
        endcase
        if (!have) begin
            n_cmp++;
            n_fail++;
            $display("FAIL sb%0d_unexpected: got word %0h, expected none", sel, dout_w[sel]);
        end else begin
            chk($sformatf("sb%0d_dout", sel), 32'(dout_w[sel]), 32'(e.d));
            chk($sformatf("sb%0d_parity_err", sel), 32'(pe[sel]), 32'(e.pe));
            chk($sformatf("sb%0d_frame_err", sel), 32'(fe[sel]), 32'(e.fe));
        end
    endfunction

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (vld[i] && ready_l[i]) sb_pop(i);
            if (ovr[i]) ovr_cnt[i]++;
            if (brk[i]) brk_cnt[i]++;
        end
    end

    task automatic send_bit(input int sel, input logic b);
        rx_l[sel] = b;
        repeat (BIT) @(posedge clk);
        #1;
    endtask

    task automatic idle_bits(input int sel, input int n);
        for (int k = 0; k < n; k++) send_bit(sel, 1'b1);
    endtask

    task automatic send_frame(input int sel, input logic [7:0] d, input int nb, input int pm,
                              input bit flip, input int ns, input bit s2low);
        logic p;
        p = 1'b0;
        send_bit(sel, 1'b0);
        for (int k = 0; k < nb; k++) begin
            send_bit(sel, d[k]);
            p = p ^ d[k];
        end
        if (pm != 0) begin
            if (pm == 1) p = ~p;
            if (flip) p = ~p;
            send_bit(sel, p);
        end
        for (int k = 0; k < ns; k++) send_bit(sel, (k == 1 && s2low) ? 1'b0 : 1'b1);
    endtask

    initial begin
        tbl[0] = '{0, 8'h55, 8, 0, 1'b0, 1, 1'b0, 0, 8'h55, 1'b0, 1'b0};
        tbl[1] = '{0, 8'hA3, 8, 0, 1'b0, 1, 1'b0, 2, 8'hA3, 1'b0, 1'b0};
        tbl[2] = '{1, 8'h2A, 7, 2, 1'b0, 1, 1'b0, 2, 8'h2A, 1'b0, 1'b0};
        tbl[3] = '{1, 8'h2A, 7, 2, 1'b1, 1, 1'b0, 2, 8'h2A, 1'b1, 1'b0};
        tbl[4] = '{2, 8'h0F, 8, 0, 1'b0, 2, 1'b1, 2, 8'h0F, 1'b0, 1'b1};
        tbl[5] = '{2, 8'h3C, 8, 0, 1'b0, 2, 1'b0, 2, 8'h3C, 1'b0, 1'b0};

        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rx_l[i]    = 1'b1;
            ready_l[i] = 1'b1;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_dout", 32'(dout0), 32'h0);
        chk("rst_valid", 32'(vld), 32'h0);
        chk("rst_busy", 32'(bsy), 32'h0);
        chk("rst_flags", 32'({pe, fe, ovr, brk}), 32'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (8) @(posedge clk);
        #1;

        // Frame table: back-to-back 8N1, 7E1 good/bad parity, 8N2 with bad second stop.
        for (int r = 0; r < 6; r++) begin
            push(tbl[r].sel, '{d: tbl[r].ed, pe: tbl[r].epe, fe: tbl[r].efe});
            send_frame(tbl[r].sel, tbl[r].d, tbl[r].nb, tbl[r].pm, tbl[r].flip, tbl[r].ns, tbl[r].s2low);
            idle_bits(tbl[r].sel, tbl[r].gap);
        end
        chk("tbl_q0_empty", 32'(q0.size()), 32'h0);
        chk("tbl_q1_empty", 32'(q1.size()), 32'h0);
        chk("tbl_q2_empty", 32'(q2.size()), 32'h0);
        chk("tbl_valid_idle", 32'(vld), 32'h0);

        // Overrun: consumer stalled across two frames.
        ready_l[0] = 1'b0;
        send_frame(0, 8'h11, 8, 0, 1'b0, 1, 1'b0);
        idle_bits(0, 2);
        chk("ovr_first_valid", 32'(vld[0]), 32'h1);
        chk("ovr_none_yet", 32'(ovr_cnt[0]), 32'h0);
        send_frame(0, 8'h22, 8, 0, 1'b0, 1, 1'b0);
        idle_bits(0, 2);
        chk("ovr_pulses", 32'(ovr_cnt[0]), 32'h1);
        chk("ovr_dout_kept", 32'(dout0), 32'h11);
        chk("ovr_valid_held", 32'(vld[0]), 32'h1);
        push(0, '{d: 8'h11, pe: 1'b0, fe: 1'b0});
        ready_l[0] = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("ovr_valid_dropped", 32'(vld[0]), 32'h0);
        chk("ovr_q0_empty", 32'(q0.size()), 32'h0);
        chk("ovr_dout_after_accept", 32'(dout0), 32'h11);

        // Quarter-bit glitch must not start a frame.
        rx_l[0] = 1'b0;
        repeat (BIT / 4) @(posedge clk);
        #1;
        idle_bits(0, 2);
        chk("glitch_busy", 32'(bsy[0]), 32'h0);
        chk("glitch_valid", 32'(vld[0]), 32'h0);

        // Reset mid-frame while the line is still low.
        send_bit(0, 1'b0);
        rx_l[0] = 1'b0;
        repeat (BIT / 2) @(posedge clk);
        #1;
        chk("midframe_busy", 32'(bsy[0]), 32'h1);
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("midreset_busy", 32'(bsy[0]), 32'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (BIT / 2) @(posedge clk);
        #1;
        idle_bits(0, 2);
        chk("postreset_busy", 32'(bsy[0]), 32'h0);
        chk("postreset_valid", 32'(vld), 32'h0);
        push(0, '{d: 8'h7E, pe: 1'b0, fe: 1'b0});
        send_frame(0, 8'h7E, 8, 0, 1'b0, 1, 1'b0);
        idle_bits(0, 2);
        chk("postreset_q0_empty", 32'(q0.size()), 32'h0);

        // Line held low for 12 bit times.
`ifndef UART_RX_BREAK_DET_EN
        push(0, '{d: 8'h00, pe: 1'b0, fe: 1'b1});
`endif
        rx_l[0] = 1'b0;
        repeat (12 * BIT) @(posedge clk);
        #1;
        idle_bits(0, 3);
`ifdef UART_RX_BREAK_DET_EN
        chk("break_pulses", 32'(brk_cnt[0]), 32'h1);
`else
        chk("break_pulses", 32'(brk_cnt[0]), 32'h0);
`endif
        chk("break_q0_empty", 32'(q0.size()), 32'h0);
        chk("break_valid", 32'(vld[0]), 32'h0);
        chk("other_overruns", 32'(ovr_cnt[1] + ovr_cnt[2]), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
